// File: rtl/nd_array_pkg.sv
// Shared types and helpers for the N-d array scatter path: element type,
// fill/hold state encoding and the column rotation helper.
package nd_array_pkg;

  localparam int unsigned ElemW = 3;

  typedef logic [ElemW-1:0] elem_t;

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } state_e;

  // Rotated column for the k-th element of a row; compare-and-subtract, no divider.
  function automatic int unsigned rot_idx(int unsigned k, int unsigned rot, int unsigned cols);
    int unsigned sum;
    sum = k + rot;
    if (sum >= cols) begin
      sum = sum - cols;
    end
    return sum;
  endfunction

endpackage

// File: rtl/nd_index_counter.sv
// Column/row position counter for frame assembly. Advances on each accepted
// element, wraps columns into rows and flags the last element of the frame.
module nd_index_counter #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 4,
  parameter int unsigned CW   = $clog2(COLS),
  parameter int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] col_cnt,
  output logic [RW-1:0] row_cnt,
  output logic          last
);

  logic col_wrap;

  always_comb begin
    col_wrap = (col_cnt == CW'(COLS - 1));
    last     = col_wrap && (row_cnt == RW'(ROWS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (step) begin
      if (col_wrap) begin
        col_cnt <= '0;
        row_cnt <= last ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nd_array_scatter.sv
// Streams W-bit elements into a packed [ROWS][COLS][W] frame with a fixed column
// rotation. Define ND_SCATTER_PINGPONG_EN for a separate assembly buffer that overlaps drain.
module nd_array_scatter
  import nd_array_pkg::*;
#(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 4,
  parameter int unsigned W    = 3,
  parameter int unsigned ROT  = 1
) (
  input  logic                             CLK,
  input  logic                             ASYNCRESETN,
  input  logic [W-1:0]                     I,
  input  logic                             I_valid,
  output logic                             I_ready,
  output logic [ROWS-1:0][COLS-1:0][W-1:0] O,
  output logic                             O_valid,
  input  logic                             O_ready
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e        state_q;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_idx;
  logic [CW:0]   col_sum;
  logic          last;
  logic          accept;
  logic          drain;

  nd_index_counter #(
    .ROWS(ROWS),
    .COLS(COLS),
    .CW  (CW),
    .RW  (RW)
  ) u_index (
    .clk    (CLK),
    .rst_n  (ASYNCRESETN),
    .step   (accept),
    .col_cnt(col_cnt),
    .row_cnt(row_cnt),
    .last   (last)
  );

  // One bit of headroom so col_cnt + ROT never overflows before the compare.
  always_comb begin
    col_sum = {1'b0, col_cnt} + (CW + 1)'(ROT);
    if (col_sum >= (CW + 1)'(COLS)) begin
      col_sum = col_sum - (CW + 1)'(COLS);
    end
    col_idx = col_sum[CW-1:0];
  end

  assign O_valid = (state_q == StHold);
  assign drain   = O_valid & O_ready;
  assign accept  = I_valid & I_ready;

`ifdef ND_SCATTER_PINGPONG_EN

  logic [ROWS-1:0][COLS-1:0][W-1:0] asm_q;
  logic [ROWS-1:0][COLS-1:0][W-1:0] frame_next;

  // Only the completing element stalls, and only if the output slot cannot free up.
  assign I_ready = !(last && O_valid && !O_ready);

  always_comb begin
    frame_next                   = asm_q;
    frame_next[row_cnt][col_idx] = I;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= StFill;
      asm_q   <= '0;
      O       <= '0;
    end else begin
      if (accept) begin
        asm_q[row_cnt][col_idx] <= I;
      end
      if (accept && last) begin
        O       <= frame_next;
        state_q <= StHold;
      end else if (drain) begin
        state_q <= StFill;
      end
    end
  end

`else

  assign I_ready = (state_q == StFill);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= StFill;
      O       <= '0;
    end else begin
      if (accept) begin
        O[row_cnt][col_idx] <= I;
      end
      if (accept && last) begin
        state_q <= StHold;
      end else if (drain) begin
        state_q <= StFill;
      end
    end
  end

`endif

endmodule

// File: tb/tb_nd_array_scatter.sv
// Directed scoreboard bench for nd_array_scatter (ROWS=2, COLS=4, W=3, ROT=1).
module tb_nd_array_scatter;

  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 4;
  localparam int unsigned W    = 3;
  localparam int unsigned ROT  = 1;
  localparam int unsigned N    = ROWS * COLS;
`ifdef ND_SCATTER_PINGPONG_EN
  localparam int unsigned GAP        = N;
  localparam int unsigned SEAM_STALL = 0;
  localparam logic        HOLD_READY = 1'b1;
`else
  localparam int unsigned GAP        = N + 1;
  localparam int unsigned SEAM_STALL = 1;
  localparam logic        HOLD_READY = 1'b0;
`endif

  typedef logic [ROWS-1:0][COLS-1:0][W-1:0] frame_t;

  logic         CLK         = 1'b0;
  logic         ASYNCRESETN = 1'b0;
  logic [W-1:0] I           = '0;
  logic         I_valid     = 1'b0;
  logic         I_ready;
  frame_t       O;
  logic         O_valid;
  logic         O_ready     = 1'b0;

  int     checks = 0;
  int     passes = 0;
  int     fails  = 0;
  int     cyc    = 0;
  frame_t sb[$];
  int     hs_cyc[$];
  frame_t last_exp;
  logic [W-1:0] vals [N];

  nd_array_scatter #(
    .ROWS(ROWS),
    .COLS(COLS),
    .W   (W),
    .ROT (ROT)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I          (I),
    .I_valid    (I_valid),
    .I_ready    (I_ready),
    .O          (O),
    .O_valid    (O_valid),
    .O_ready    (O_ready)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Element k of row r lands at column (k + ROT) mod COLS.
  function automatic frame_t model();
    frame_t f;
    f = '0;
    for (int k = 0; k < int'(N); k++) begin
      f[k / COLS][(k % COLS + ROT) % COLS] = vals[k];
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, output int stalls);
    bit took;
    stalls  = 0;
    I       = v;
    I_valid = 1'b1;
    forever begin
      took = I_ready;
      tick();
      if (took) break;
      stalls++;
      if (stalls > 40) begin
        check("send_timeout", 64'(stalls), 64'd0);
        break;
      end
    end
    I_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gap, output int stalls);
    int s;
    stalls   = 0;
    last_exp = model();
    sb.push_back(last_exp);
    for (int k = 0; k < int'(N); k++) begin
      send(vals[k], s);
      stalls += s;
      if (gap && k < int'(N) - 1) begin
        check("o_valid_low_mid_frame", 64'(O_valid), 64'd0);
        tick();
      end
    end
  endtask

  // Scoreboard: every output handshake pops and compares one expected frame.
  always @(negedge CLK) begin
    if (ASYNCRESETN && O_valid && O_ready) begin
      hs_cyc.push_back(cyc);
      check("frame_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("frame_data", 64'(O), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    int st;
    int st2;

    #2;
    check("rst_i_ready_in_reset", 64'(I_ready), 64'd1);
    check("rst_o_in_reset", 64'(O), 64'd0);
    check("rst_o_valid_in_reset", 64'(O_valid), 64'd0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    tick();
    check("rst_o", 64'(O), 64'd0);
    check("rst_o_valid", 64'(O_valid), 64'd0);
    check("rst_i_ready", 64'(I_ready), 64'd1);

    // Back-to-back 0..7 with the consumer stalled.
    for (int k = 0; k < int'(N); k++) vals[k] = W'(k);
    send_frame(1'b0, st);
    check("b2b_stalls", 64'(st), 64'd0);
    check("b2b_o_valid_latency", 64'(O_valid), 64'd1);
    check("b2b_o_0_1", 64'(O[0][1]), 64'd0);
    check("b2b_o_0_0", 64'(O[0][0]), 64'd3);
    check("b2b_o_1_1", 64'(O[1][1]), 64'd4);
    check("b2b_o_1_0", 64'(O[1][0]), 64'd7);
    for (int c = 0; c < 5; c++) begin
      check("hold_o_stable", 64'(O), 64'(last_exp));
      check("hold_o_valid", 64'(O_valid), 64'd1);
      check("hold_i_ready", 64'(I_ready), 64'(HOLD_READY));
      tick();
    end
    O_ready = 1'b1;
    tick();
    O_ready = 1'b0;
    check("release_o_valid", 64'(O_valid), 64'd0);
    check("release_i_ready", 64'(I_ready), 64'd1);

    // I_valid toggling 1/0 with values 7..0, consumer ready.
    O_ready = 1'b1;
    for (int k = 0; k < int'(N); k++) vals[k] = W'(N - 1 - k);
    send_frame(1'b1, st);
    check("toggle_o_valid_latency", 64'(O_valid), 64'd1);
    tick();
    check("toggle_one_cycle_valid", 64'(O_valid), 64'd0);

    // Reset mid-frame after 5 elements; O_ready high in FILL must be ignored.
    for (int k = 0; k < 5; k++) send(W'(k + 1), st);
    check("fill_ignores_o_ready", 64'(O_valid), 64'd0);
    #1 ASYNCRESETN = 1'b0;
    #1;
    check("async_rst_o", 64'(O), 64'd0);
    check("async_rst_o_valid", 64'(O_valid), 64'd0);
    check("async_rst_i_ready", 64'(I_ready), 64'd1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    tick();
    for (int k = 0; k < int'(N); k++) vals[k] = W'($urandom_range(0, (1 << W) - 1));
    send_frame(1'b0, st);
    check("post_rst_o_valid", 64'(O_valid), 64'd1);
    check("post_rst_first_col", 64'(O[0][ROT]), 64'(vals[0]));
    tick();

    // Two frames with I_valid and O_ready held high.
    hs_cyc.delete();
    for (int k = 0; k < int'(N); k++) vals[k] = W'(k);
    send_frame(1'b0, st);
    for (int k = 0; k < int'(N); k++) vals[k] = W'(k + 8);
    send_frame(1'b0, st2);
    check("stream_first_stalls", 64'(st), 64'd0);
    check("stream_seam_stalls", 64'(st2), 64'(SEAM_STALL));
    repeat (3) tick();
    check("stream_frame_count", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() == 2) begin
      check("stream_frame_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'(GAP));
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    if (fails == 0) $display("all comparisons matched");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
